// File: rtl/edac.sv
// Shared Hsiao (39,32) SECDED checksum used by every EDAC user in the core.
// Each data column is a distinct weight-3 7-bit value; check-bit columns are one-hot.
package edac;

  // Weight-3 values in ascending order, first 32 of the 35 available.
  localparam logic [6:0] EDAC_COLS [32] = '{
    7'h07, 7'h0B, 7'h0D, 7'h0E, 7'h13, 7'h15, 7'h16, 7'h19,
    7'h1A, 7'h1C, 7'h23, 7'h25, 7'h26, 7'h29, 7'h2A, 7'h2C,
    7'h31, 7'h32, 7'h34, 7'h38, 7'h43, 7'h45, 7'h46, 7'h49,
    7'h4A, 7'h4C, 7'h51, 7'h52, 7'h54, 7'h58, 7'h61, 7'h62
  };

  function automatic logic [6:0] edac_checksum(input logic [31:0] data);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      if (data[i]) c = c ^ EDAC_COLS[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/secded_lane_codec.sv
// Two-stage multi-lane SECDED encoder / checker-corrector with valid/ready flow
// control and saturating corrected/uncorrectable event counters.
module secded_lane_codec #(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                  s_clk_i,
  input  logic                  s_resetn_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic                  s_mode_i,
  input  logic [32*LANES-1:0]   s_data_i,
  input  logic [7*LANES-1:0]    s_checksum_i,
  output logic                  s_valid_o,
  input  logic                  s_ready_i,
  output logic [32*LANES-1:0]   s_data_o,
  output logic [7*LANES-1:0]    s_checksum_o,
  output logic [LANES-1:0]      s_ce_o,
  output logic [LANES-1:0]      s_ue_o,
  input  logic                  s_cnt_clr_i,
  output logic [CNT_W-1:0]      s_ce_cnt_o,
  output logic [CNT_W-1:0]      s_ue_cnt_o
);
  import edac::*;

  // Handshake: a beat moves across an interface on a clock edge where that
  // interface's valid and ready are both high. Both stages advance together
  // whenever stage 2 is empty or being drained, so s_ready_o follows s_ready_i
  // combinationally and a stalled output holds every output bit stable.

  logic                  w_adv;
  logic [7*LANES-1:0]    w_syn;
  logic [32*LANES-1:0]   w_data_c;
  logic [7*LANES-1:0]    w_chk_c;
  logic [LANES-1:0]      w_ce;
  logic [LANES-1:0]      w_ue;

  logic                  r_v1;
  logic                  r_mode1;
  logic [32*LANES-1:0]   r_data1;
  logic [7*LANES-1:0]    r_syn1;

  logic                  r_v2;
  logic [32*LANES-1:0]   r_data2;
  logic [7*LANES-1:0]    r_chk2;
  logic [LANES-1:0]      r_ce2;
  logic [LANES-1:0]      r_ue2;

  logic [CNT_W-1:0]      r_ce_cnt;
  logic [CNT_W-1:0]      r_ue_cnt;

  assign w_adv = !r_v2 || s_ready_i;

  always_comb begin
    w_syn = '0;
    for (int k = 0; k < LANES; k++) begin
      if (s_mode_i) begin
        w_syn[7*k +: 7] = edac_checksum(s_data_i[32*k +: 32]) ^ s_checksum_i[7*k +: 7];
      end
    end
  end

  always_comb begin : correct
    logic [6:0]  syn;
    logic [31:0] dat;
    logic        hit;
    logic        one_hot;
    syn      = '0;
    dat      = '0;
    hit      = 1'b0;
    one_hot  = 1'b0;
    w_data_c = '0;
    w_chk_c  = '0;
    w_ce     = '0;
    w_ue     = '0;
    for (int k = 0; k < LANES; k++) begin
      syn = r_syn1[7*k +: 7];
      dat = r_data1[32*k +: 32];
      hit = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (syn == EDAC_COLS[i]) begin
          dat[i] = ~dat[i];
          hit    = 1'b1;
        end
      end
      // One-hot syndrome means a flipped check bit: data is already correct.
      one_hot = (syn != 7'd0) && ((syn & (syn - 7'd1)) == 7'd0);
      w_data_c[32*k +: 32] = dat;
      w_chk_c[7*k +: 7]    = edac_checksum(dat);
      w_ce[k] = r_mode1 && (hit || one_hot);
      w_ue[k] = r_mode1 && (syn != 7'd0) && !(hit || one_hot);
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_v1    <= 1'b0;
      r_mode1 <= 1'b0;
      r_data1 <= '0;
      r_syn1  <= '0;
      r_v2    <= 1'b0;
      r_data2 <= '0;
      r_chk2  <= '0;
      r_ce2   <= '0;
      r_ue2   <= '0;
    end else if (w_adv) begin
      r_v1    <= s_valid_i;
      r_mode1 <= s_mode_i;
      r_data1 <= s_data_i;
      r_syn1  <= w_syn;
      r_v2    <= r_v1;
      r_data2 <= w_data_c;
      r_chk2  <= w_chk_c;
      r_ce2   <= w_ce;
      r_ue2   <= w_ue;
    end
  end

  // Wide enough that adding up to LANES events to a full counter cannot wrap.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [LANES-1:0] flags);
    logic [CNT_W+LANES-1:0] sum;
    sum = {{LANES{1'b0}}, cnt};
    for (int k = 0; k < LANES; k++) begin
      sum = sum + {{(CNT_W+LANES-1){1'b0}}, flags[k]};
    end
    if (sum > {{LANES{1'b0}}, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_ce_cnt <= '0;
      r_ue_cnt <= '0;
    end else if (s_cnt_clr_i) begin
      r_ce_cnt <= '0;
      r_ue_cnt <= '0;
    end else if (r_v2 && s_ready_i) begin
      r_ce_cnt <= sat_add(r_ce_cnt, r_ce2);
      r_ue_cnt <= sat_add(r_ue_cnt, r_ue2);
    end
  end

  assign s_ready_o    = w_adv;
  assign s_valid_o    = r_v2;
  assign s_data_o     = r_data2;
  assign s_checksum_o = r_chk2;
  assign s_ce_o       = r_ce2;
  assign s_ue_o       = r_ue2;
  assign s_ce_cnt_o   = r_ce_cnt;
  assign s_ue_cnt_o   = r_ue_cnt;

endmodule

// File: tb/tb_secded_lane_codec.sv
// Self-checking bench for secded_lane_codec: vector table, scoreboard queue,
// backpressure, counter saturation/clear and mid-stream reset sequences.
module tb_secded_lane_codec;
  localparam int LANES = 2;
  localparam int DW    = 32 * LANES;
  localparam int CW    = 7 * LANES;
  localparam int SAT_MAX = 3;
  localparam int BIG_MAX = 65535;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_mode;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_chk;
  logic          out_ready;
  logic          cnt_clr;

  logic             m_ready, m_valid;
  logic [DW-1:0]    m_data;
  logic [CW-1:0]    m_chk;
  logic [LANES-1:0] m_ce, m_ue;
  logic [15:0]      m_ce_cnt, m_ue_cnt;

  logic             s_ready, s_valid;
  logic [DW-1:0]    s_data;
  logic [CW-1:0]    s_chk;
  logic [LANES-1:0] s_ce, s_ue;
  logic [1:0]       s_ce_cnt, s_ue_cnt;

  secded_lane_codec #(.LANES(LANES), .CNT_W(16)) u_dut (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_valid_i(in_valid), .s_ready_o(m_ready),
    .s_mode_i(in_mode), .s_data_i(in_data), .s_checksum_i(in_chk),
    .s_valid_o(m_valid), .s_ready_i(out_ready), .s_data_o(m_data),
    .s_checksum_o(m_chk), .s_ce_o(m_ce), .s_ue_o(m_ue), .s_cnt_clr_i(cnt_clr),
    .s_ce_cnt_o(m_ce_cnt), .s_ue_cnt_o(m_ue_cnt)
  );

  secded_lane_codec #(.LANES(LANES), .CNT_W(2)) u_sat (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_valid_i(in_valid), .s_ready_o(s_ready),
    .s_mode_i(in_mode), .s_data_i(in_data), .s_checksum_i(in_chk),
    .s_valid_o(s_valid), .s_ready_i(out_ready), .s_data_o(s_data),
    .s_checksum_o(s_chk), .s_ce_o(s_ce), .s_ue_o(s_ue), .s_cnt_clr_i(cnt_clr),
    .s_ce_cnt_o(s_ce_cnt), .s_ue_cnt_o(s_ue_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [DW-1:0]    data;
    logic [CW-1:0]    chk;
    logic [LANES-1:0] ce;
    logic [LANES-1:0] ue;
  } exp_t;

  typedef struct {
    logic          mode;
    logic [DW-1:0] data;
    logic [CW-1:0] chk;
    logic [DW-1:0] exp_data;
    logic [LANES-1:0] exp_ce;
    logic [LANES-1:0] exp_ue;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        tbl[7];
  logic [6:0]  cols[32];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mv1, mv2;
  int unsigned mc_ce, mc_ue, sc_ce, sc_ue;

  // Columns derived independently: weight-3 values in ascending order.
  task automatic build_cols();
    int n;
    logic [7:0] v;
    n = 0;
    for (int x = 0; x < 128; x++) begin
      v = x[7:0];
      if (n < 32 && $countones(v) == 3) begin
        cols[n] = v[6:0];
        n++;
      end
    end
  endtask

  function automatic logic [6:0] ref_cks(input logic [31:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) if (d[i]) c = c ^ cols[i];
    return c;
  endfunction

  function automatic exp_t ref_beat(input logic mode, input logic [DW-1:0] d,
                                    input logic [CW-1:0] c);
    exp_t e;
    logic [31:0] dk;
    logic [6:0]  syn;
    logic        hit;
    e = '0;
    for (int k = 0; k < LANES; k++) begin
      dk  = d[32*k +: 32];
      syn = mode ? (ref_cks(dk) ^ c[7*k +: 7]) : 7'd0;
      hit = 1'b0;
      for (int i = 0; i < 32; i++) if (syn == cols[i]) begin dk[i] = ~dk[i]; hit = 1'b1; end
      e.ce[k] = hit || ($countones(syn) == 1);
      e.ue[k] = (syn != 7'd0) && !e.ce[k];
      e.data[32*k +: 32] = dk;
      e.chk[7*k +: 7]    = ref_cks(dk);
    end
    return e;
  endfunction

  function automatic exp_t tbl_beat(input vec_t v);
    exp_t e;
    e.data = v.exp_data;
    for (int k = 0; k < LANES; k++) e.chk[7*k +: 7] = ref_cks(v.exp_data[32*k +: 32]);
    e.ce = v.exp_ce;
    e.ue = v.exp_ue;
    return e;
  endfunction

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned mx);
    return (a + b > mx) ? mx : a + b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Called right after inputs change at the falling edge; samples 1 time unit later.
  task automatic step(input exp_t e_push, output bit acc);
    bit   adv;
    exp_t e;
    #1;
    adv = !mv2 || out_ready;
    check("ce_cnt", 64'(m_ce_cnt), 64'(mc_ce));
    check("ue_cnt", 64'(m_ue_cnt), 64'(mc_ue));
    check("sat_ce_cnt", 64'(s_ce_cnt), 64'(sc_ce));
    check("sat_ue_cnt", 64'(s_ue_cnt), 64'(sc_ue));
    check("valid_o", 64'(m_valid), 64'(mv2));
    check("ready_o", 64'(m_ready), 64'(adv));
    check("sat_valid_o", 64'(s_valid), 64'(mv2));
    check("sat_ready_o", 64'(s_ready), 64'(adv));
    if (mv2) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q[0];
        check("data_o", m_data, 64'(e.data));
        check("chk_o", 64'(m_chk), 64'(e.chk));
        check("ce_o", 64'(m_ce), 64'(e.ce));
        check("ue_o", 64'(m_ue), 64'(e.ue));
        check("sat_data_o", s_data, 64'(e.data));
        check("sat_chk_o", 64'(s_chk), 64'(e.chk));
        check("sat_flags_o", 64'({s_ce, s_ue}), 64'({e.ce, e.ue}));
        if (out_ready) begin
          void'(exp_q.pop_front());
          mc_ce = sat_add(mc_ce, $countones(e.ce), BIG_MAX);
          mc_ue = sat_add(mc_ue, $countones(e.ue), BIG_MAX);
          sc_ce = sat_add(sc_ce, $countones(e.ce), SAT_MAX);
          sc_ue = sat_add(sc_ue, $countones(e.ue), SAT_MAX);
        end
      end
    end
    if (cnt_clr) begin
      mc_ce = 0; mc_ue = 0; sc_ce = 0; sc_ue = 0;
    end
    acc = in_valid && adv;
    if (acc) exp_q.push_back(e_push);
    if (adv) begin
      mv2 = mv1;
      mv1 = in_valid;
    end
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input logic rdy);
    bit a;
    in_valid = 1'b0; out_ready = rdy;
    step('0, a);
  endtask

  task automatic send(input logic mode, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic rdy, output bit acc);
    in_valid = 1'b1; in_mode = mode; in_data = d; in_chk = c; out_ready = rdy;
    step(ref_beat(mode, d, c), acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) idle(1'b1);
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [CW-1:0] good_chk(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    for (int k = 0; k < LANES; k++) c[7*k +: 7] = ref_cks(d[32*k +: 32]);
    return c;
  endfunction

  task automatic set_vec(input int idx, input logic mode,
                         input logic [31:0] d1, input logic [31:0] d0,
                         input logic [6:0] c1, input logic [6:0] c0,
                         input logic [31:0] e1, input logic [31:0] e0,
                         input logic [1:0] ce, input logic [1:0] ue);
    tbl[idx].mode = mode;
    tbl[idx].data = {d1, d0};
    tbl[idx].chk = {c1, c0};
    tbl[idx].exp_data = {e1, e0};
    tbl[idx].exp_ce = ce;
    tbl[idx].exp_ue = ue;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit            acc;
    int            idx;
    logic [DW-1:0] d, bp_data[6];
    logic [CW-1:0] c;
    logic [31:0]   flip;
    int            nerr_bits;

    build_cols();
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; in_chk = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    mv1 = 0; mv2 = 0; mc_ce = 0; mc_ue = 0; sc_ce = 0; sc_ue = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_valid_o", 64'(m_valid), 64'd0);
    check("rst_ready_o", 64'(m_ready), 64'd1);
    check("rst_data_o", m_data, 64'd0);
    check("rst_chk_o", 64'(m_chk), 64'd0);
    check("rst_flags_o", 64'({m_ce, m_ue}), 64'd0);
    check("rst_cnts", 64'({m_ce_cnt, m_ue_cnt}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    set_vec(0, 1'b1, 32'hDEADBEEF, 32'h0, ref_cks(32'hDEADBEEF), 7'h00,
            32'hDEADBEEF, 32'h0, 2'b00, 2'b00);
    set_vec(1, 1'b1, 32'h0, 32'h00000020, 7'h00, 7'h00, 32'h0, 32'h0, 2'b01, 2'b00);
    set_vec(2, 1'b1, 32'h00000003, 32'h0, 7'h00, 7'h01,
            32'h00000003, 32'h0, 2'b01, 2'b10);
    set_vec(3, 1'b0, 32'hFFFFFFFF, 32'h12345678, 7'h7F, 7'h55,
            32'hFFFFFFFF, 32'h12345678, 2'b00, 2'b00);
    set_vec(4, 1'b1, 32'hDEADBEEE, 32'h80000000, ref_cks(32'hDEADBEEF), 7'h00,
            32'hDEADBEEF, 32'h0, 2'b11, 2'b00);
    set_vec(5, 1'b1, 32'hCAFEF00D, 32'h0, ref_cks(32'hCAFEF00D) ^ 7'h40, 7'h70,
            32'hCAFEF00D, 32'h0, 2'b10, 2'b01);
    set_vec(6, 1'b1, 32'hFFFFFFFF, 32'hA5A5A6A5, ref_cks(32'hFFFFFFFF), ref_cks(32'hA5A5A5A5),
            32'hFFFFFFFF, 32'hA5A5A6A5, 2'b00, 2'b01);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_mode = tbl[i].mode; in_data = tbl[i].data; in_chk = tbl[i].chk;
      out_ready = 1'b1;
      step(tbl_beat(tbl[i]), acc);
    end
    drain();

    // Backpressure: 6 encode beats, sink stalls in cycles 3..5
    for (int i = 0; i < 6; i++) bp_data[i] = {$urandom(), $urandom()};
    idx = 0;
    for (int cyc = 0; cyc < 30 && idx < 6; cyc++) begin
      send(1'b0, bp_data[idx], CW'($urandom()), !(cyc >= 3 && cyc <= 5), acc);
      if (acc) idx++;
    end
    check("bp_all_accepted", 64'(idx), 64'd6);
    drain();

    // Random check/encode traffic with 0, 1 or 2 injected bit errors per lane
    for (int i = 0; i < 60; i++) begin
      d = {$urandom(), $urandom()};
      c = good_chk(d);
      for (int k = 0; k < LANES; k++) begin
        nerr_bits = $urandom_range(0, 2);
        for (int j = 0; j < nerr_bits; j++) begin
          if ($urandom_range(0, 3) == 0) c[7*k + $urandom_range(0, 6)] ^= 1'b1;
          else begin
            flip = 32'b1 << $urandom_range(0, 31);
            d[32*k +: 32] = d[32*k +: 32] ^ flip;
          end
        end
      end
      if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 3) != 0);
      else send($urandom_range(0, 5) != 0, d, c, $urandom_range(0, 3) != 0, acc);
    end
    drain();

    // Saturation: clear, then 5 beats with a corrected error in both lanes
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
    step('0, acc);
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = {32'h00000001 << i, 32'h00010000 << i};
      send(1'b1, d, good_chk('0), 1'b1, acc);
    end
    drain();
    #1;
    check("sat_ce_stuck", 64'(s_ce_cnt), 64'd3);
    check("big_ce_ten", 64'(m_ce_cnt), 64'd10);
    @(negedge clk);

    // Clear in the same cycle as a flagged handshake
    send(1'b1, {32'h0, 32'h00000100}, '0, 1'b0, acc);
    idle(1'b0);
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b1;
    step('0, acc);
    cnt_clr = 1'b0;
    #1;
    check("clr_wins_ce", 64'(m_ce_cnt), 64'd0);
    check("clr_wins_sat_ce", 64'(s_ce_cnt), 64'd0);
    @(negedge clk);

    // Reset mid-stream with both stages full
    send(1'b1, {32'h00000003, 32'h00000004}, '0, 1'b1, acc);
    drain();
    send(1'b1, {32'h0, 32'h00000008}, '0, 1'b0, acc);
    send(1'b1, {32'h0, 32'h00000010}, '0, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_o", 64'(m_valid), 64'd0);
    check("midrst_sat_valid_o", 64'(s_valid), 64'd0);
    check("midrst_cnts", 64'({m_ce_cnt, m_ue_cnt}), 64'd0);
    exp_q.delete();
    mv1 = 0; mv2 = 0; mc_ce = 0; mc_ue = 0; sc_ce = 0; sc_ue = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) idle(1'b1);
    send(1'b1, {32'h12345678, 32'h00000040}, good_chk({32'h12345678, 32'h0}), 1'b1, acc);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
